// File: rtl/data_mem_if.sv
// Request/response bundle between the control unit (master) and the data memory controller (slave).
// DATA_MEM_PARITY_EN adds the parity_inj / parity_err signals.
interface data_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              MW;
    logic [ADDR_W-1:0] bus_A;
    logic [DATA_W-1:0] bus_B;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] mem_out;
    logic              addr_err;
`ifdef DATA_MEM_PARITY_EN
    logic              parity_inj;
    logic              parity_err;

    modport master (output start, MW, bus_A, bus_B, parity_inj,
                    input  busy, done, mem_out, addr_err, parity_err);
    modport slave  (input  start, MW, bus_A, bus_B, parity_inj,
                    output busy, done, mem_out, addr_err, parity_err);
`else
    modport master (output start, MW, bus_A, bus_B,
                    input  busy, done, mem_out, addr_err);
    modport slave  (input  start, MW, bus_A, bus_B,
                    output busy, done, mem_out, addr_err);
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port synchronous data RAM behind a start/busy/done handshake with programmable wait cycles.
// Optional per-word parity bit when DATA_MEM_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched when it arrives
// ACCESS | counting down wait cycles; RAM access on the edge the counter is zero
// DONE   | one-cycle completion, done/addr_err/parity_err valid
module data_mem_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYC);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              mw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem_out_q;
    logic              addr_err_q;
    logic              in_range;
    logic              fire;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] ram [DEPTH];

    // Extended compare so DEPTH == 2**ADDR_W never flags an error and nothing wraps.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign fire     = (state == S_ACCESS) && (cnt == 4'd0);
    assign idx      = addr_q[IDX_W-1:0];

`ifdef DATA_MEM_PARITY_EN
    logic ram_par [DEPTH];
    logic inj_q;
    logic parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            mw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mem_out_q  <= '0;
            addr_err_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            inj_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            addr_err_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mw_q   <= bus.MW;
                        addr_q <= bus.bus_A;
                        data_q <= bus.bus_B;
                        cnt    <= WAIT_L;
                        state  <= S_ACCESS;
`ifdef DATA_MEM_PARITY_EN
                        inj_q  <= bus.parity_inj;
`endif
                    end
                end
                S_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= S_DONE;
                        addr_err_q <= ~in_range;
                        if (!mw_q) begin
                            mem_out_q <= in_range ? ram[idx] : '0;
`ifdef DATA_MEM_PARITY_EN
                            parity_err_q <= in_range & (ram_par[idx] ^ (^ram[idx]));
`endif
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is never reset; a reset edge simply blocks the pending write.
    always_ff @(posedge clk) begin
        if (!reset && fire && mw_q && in_range) begin
            ram[idx] <= data_q;
`ifdef DATA_MEM_PARITY_EN
            ram_par[idx] <= (^data_q) ^ inj_q;
`endif
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.mem_out  = mem_out_q;
    assign bus.addr_err = addr_err_q;
`ifdef DATA_MEM_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: DEPTH=128/WAIT_CYC=1 main instance plus a full-depth WAIT_CYC=0 one.
// Parity scenarios are built only when DATA_MEM_PARITY_EN is defined.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_if #(.DATA_W(8), .ADDR_W(8)) b ();
    data_mem_if #(.DATA_W(8), .ADDR_W(8)) b2 ();

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYC(1)) dut (
        .clk(clk), .reset(reset), .bus(b));
    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) dut2 (
        .clk(clk), .reset(reset), .bus(b2));

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       err;
        logic       perr;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] mdl [256];
    logic       mpar [256];
    logic [7:0] last_rd;
    int         tests  = 0;
    int         errors = 0;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && b.done) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: done seen with no request outstanding");
            end else begin
                e = sb.pop_front();
                if (b.mem_out !== e.data || b.addr_err !== e.err) begin
                    errors++;
                    $display("FAIL sb_done rd=%0b: mem_out=%h addr_err=%b, expected mem_out=%h addr_err=%b",
                             e.rd, b.mem_out, b.addr_err, e.data, e.err);
                end
`ifdef DATA_MEM_PARITY_EN
                tests++;
                if (b.parity_err !== e.perr) begin
                    errors++;
                    $display("FAIL sb_parity: parity_err=%b expected %b", b.parity_err, e.perr);
                end
`endif
            end
        end
    end

    task automatic issue(input logic mw, input logic [7:0] a, input logic [7:0] d,
                         input logic inj, input bit push, input bit now);
        exp_t x;
        if (!now) @(negedge clk);
        b.start = 1'b1; b.MW = mw; b.bus_A = a; b.bus_B = d;
`ifdef DATA_MEM_PARITY_EN
        b.parity_inj = inj;
`endif
        if (push) begin
            x.rd  = ~mw;
            x.err = (a >= 8'd128);
            if (mw) begin
                if (!x.err) begin mdl[a] = d; mpar[a] = inj; end
                x.data = last_rd;
                x.perr = 1'b0;
            end else begin
                x.data  = x.err ? 8'h00 : mdl[a];
                x.perr  = x.err ? 1'b0 : mpar[a];
                last_rd = x.data;
            end
            sb.push_back(x);
        end
        @(negedge clk);
        b.start = 1'b0;
        b.MW    = 1'($urandom);
        b.bus_A = 8'($urandom);
        b.bus_B = 8'($urandom);
`ifdef DATA_MEM_PARITY_EN
        b.parity_inj = 1'($urandom);
`endif
    endtask

    // Measures busy length and done position starting at the first cycle after the start edge.
    task automatic wait_idle(output int nbusy, output int done_at);
        nbusy   = 0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (b.done) done_at = k;
            if (!b.busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b.start = 1'b0; b.MW = 1'b0; b.bus_A = '0; b.bus_B = '0;
        b2.start = 1'b0; b2.MW = 1'b0; b2.bus_A = '0; b2.bus_B = '0;
`ifdef DATA_MEM_PARITY_EN
        b.parity_inj = 1'b0; b2.parity_inj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if (b.busy !== 1'b0 || b.done !== 1'b0 || b.mem_out !== 8'h00 || b.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b mem_out=%h addr_err=%b, expected 0 0 00 0",
                     b.busy, b.done, b.mem_out, b.addr_err);
        end
`ifdef DATA_MEM_PARITY_EN
        tests++;
        if (b.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity_err: got %b expected 0", b.parity_err);
        end
`endif
        reset   = 1'b0;
        last_rd = 8'h00;
    endtask

    task automatic test_write();
        int nb, da;
        issue(1'b1, 8'h10, 8'hA5, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (nb != 3 || da != 3) begin
            errors++;
            $display("FAIL write_latency: busy_cycles=%0d done_cycle=%0d, expected 3 and 3", nb, da);
        end
    endtask

    task automatic test_read();
        int nb, da;
        issue(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (nb != 3 || da != 3 || b.mem_out !== 8'hA5) begin
            errors++;
            $display("FAIL read_hold: busy=%0d done=%0d mem_out=%h, expected 3 3 a5", nb, da, b.mem_out);
        end
        issue(1'b1, 8'h11, 8'h5B, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (b.mem_out !== 8'hA5) begin
            errors++;
            $display("FAIL write_keeps_mem_out: mem_out=%h expected a5", b.mem_out);
        end
    endtask

    task automatic test_start_ignored();
        int nb, da;
        issue(1'b1, 8'h20, 8'h11, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        b.start = 1'b1; b.MW = 1'b1; b.bus_A = 8'h20; b.bus_B = 8'h3C;
        @(negedge clk);
        b.start = 1'b0;
        @(negedge clk);
        tests++;
        if (b.done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done_cycle: done=%b expected 1", b.done);
        end
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        tests++;
        if (b.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_busy: busy=%b expected 0", b.busy);
        end
        issue(1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (b.mem_out !== 8'h11) begin
            errors++;
            $display("FAIL ignore_readback: mem_out=%h expected 11", b.mem_out);
        end
    endtask

    task automatic test_back_to_back();
        int nb, da;
        issue(1'b1, 8'h30, 8'h99, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 1'b1);
        tests++;
        if (b.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b expected 1", b.busy);
        end
        wait_idle(nb, da);
        tests++;
        if (nb != 3 || da != 3) begin
            errors++;
            $display("FAIL b2b_latency: busy=%0d done=%0d expected 3 3", nb, da);
        end
    endtask

    task automatic test_out_of_range();
        int nb, da;
        issue(1'b1, 8'h7F, 8'h3E, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (b.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_clear: addr_err=%b expected 0 after done", b.addr_err);
        end
        issue(1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        tests++;
        if (b.mem_out !== 8'h3E) begin
            errors++;
            $display("FAIL oor_edge_read: mem_out=%h expected 3e", b.mem_out);
        end
    endtask

    task automatic test_reset_mid();
        int nb, da;
        issue(1'b1, 8'h05, 8'h42, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b1, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (b.busy !== 1'b0 || b.done !== 1'b0 || b.mem_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b mem_out=%h expected 0 0 00", b.busy, b.done, b.mem_out);
        end
        reset   = 1'b0;
        last_rd = 8'h00;
        issue(1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity();
        int nb, da;
        issue(1'b1, 8'h40, 8'h5A, 1'b1, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b1, 8'h40, 8'h5A, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 1'b0);
        wait_idle(nb, da);
        issue(1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_idle(nb, da);
    endtask
`endif

    task automatic test_full_depth();
        @(negedge clk);
        b2.start = 1'b1; b2.MW = 1'b1; b2.bus_A = 8'hFF; b2.bus_B = 8'hC3;
        @(negedge clk);
        b2.start = 1'b0; b2.bus_B = 8'h00;
        tests++;
        if (b2.busy !== 1'b1 || b2.done !== 1'b0) begin
            errors++;
            $display("FAIL w0_access: busy=%b done=%b expected 1 0", b2.busy, b2.done);
        end
        @(negedge clk);
        tests++;
        if (b2.done !== 1'b1 || b2.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL w0_write_done: done=%b addr_err=%b expected 1 0", b2.done, b2.addr_err);
        end
        @(negedge clk);
        b2.start = 1'b1; b2.MW = 1'b0; b2.bus_A = 8'hFF;
        tests++;
        if (b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL w0_idle: busy=%b expected 0", b2.busy);
        end
        @(negedge clk);
        b2.start = 1'b0; b2.bus_A = 8'h00;
        @(negedge clk);
        tests++;
        if (b2.done !== 1'b1 || b2.mem_out !== 8'hC3 || b2.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL w0_read_top: done=%b mem_out=%h addr_err=%b expected 1 c3 0",
                     b2.done, b2.mem_out, b2.addr_err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_start_ignored();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        test_full_depth();
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
